device_uart_tx: RTL and testbench
=================================

# device_uart_tx

UART transmitter serialising one byte per request into an 11-bit frame: start bit, 8 data bits LSB first, even parity, stop bit. It is the transmit-side counterpart of the UART receiver and uses the same bit period, bit order and parity convention, so a TX→RX loopback round-trips data with `parityError` = 0. It sits on the peripheral bus side of the core: the CPU writes a byte, pulses start, and polls `txBusy` or takes `txInterrupt`.

## Interface
- `BAUD_CNT`, default 5199: the bit period is `BAUD_CNT`+1 clock cycles.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `transmitData`  in  8  byte to send; sampled only when a start is accepted.
- `transmitStart`  in  1  one-cycle request; ignored unless idle.
- `clearInterrupt`  in  1  clears `txInterrupt`.
- `serialDataTX`  out  1  serial line; idles high; registered.
- `txBusy`  out  1  high from the accept cycle +1 until the stop bit ends.
- `txInterrupt`  out  1  sticky frame-done flag.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `serialDataTX`=1, `txBusy`=0, tick counter held at 0.
  - `transmitStart`=1 accepts the request:
    - latch `transmitData` into the shift register;
    - compute `parity_r` = XOR of the 8 bits (even parity);
    - go to START.
- **Tick counter**
  - Counts 0..`BAUD_CNT` in every state except IDLE.
  - `bit_tick` is asserted when count = `BAUD_CNT`; the counter then wraps to 0.
- **START**: line driven 0; on `bit_tick` go to DATA with bit index 0.
- **DATA**
  - Line driven with `shift[0]`.
  - On `bit_tick`: shift right and increment the index.
  - After the tick that ends index 7, go to PARITY.
- **PARITY**: line driven with `parity_r`; on `bit_tick` go to STOP.
- **STOP**: line driven 1; on `bit_tick` go to IDLE and set `txInterrupt`.
- **`txInterrupt`**
  - Cleared by `clearInterrupt`.
  - If set and clear occur in the same cycle, set wins.
  - Unaffected by a new start.
- **Start while busy**: `transmitStart` outside IDLE is ignored; it is not queued.
- **Changing inputs**: `transmitData` changes after accept do not affect the frame in flight.
- **Reset mid-frame**
  - Aborts the frame.
  - Next cycle: `serialDataTX`=1, `txBusy`=0, `txInterrupt`=0, state IDLE, counters 0.
  - No partial stop bit is generated.

## Timing
- Reset values:
  - `serialDataTX`=1, `txBusy`=0, `txInterrupt`=0;
  - state IDLE; shift register and parity register 0.
- Start accepted at edge N:
  - `serialDataTX` falls and `txBusy` rises at N+1;
  - start bit occupies cycles N+1 .. N+`BAUD_CNT`+1.
- Bit k (start = 0, stop = 10) occupies `BAUD_CNT`+1 cycles beginning at N+1+k·(`BAUD_CNT`+1).
- End of frame:
  - `txBusy` falls and `txInterrupt` rises at N+1+11·(`BAUD_CNT`+1);
  - at that same cycle the block is in IDLE and accepts a new start.
- Back-to-back: a start accepted in the first IDLE cycle produces a start bit immediately after the stop bit, with no extra idle bit time.
- Output is registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum: IDLE, START, DATA, PARITY, STOP;
  - `UART_DATA_BITS` = 8;
  - `UART_FRAME_BITS` = 11;
  - `UART_BAUD_CNT_DEFAULT` = 5199.
- The receiver adopts the same package.
- One sub-module: `uart_baud_tick`
  - parameter `BAUD_CNT`; inputs `clk`, `rst`, `run`; output `bit_tick`;
  - the counter is cleared whenever `run`=0.
- The FSM, shift register, bit index and parity register are inline in `device_uart_tx`.

## Test plan
All scenarios use `BAUD_CNT`=3 (4 cycles/bit; 44-cycle frame).

1. Reset then idle 50 cycles → `serialDataTX`=1, `txBusy`=0, `txInterrupt`=0 throughout.
2. Send 0xA5 (even parity 0):
   - line sequence per 4 cycles: 0, 1,0,1,0,0,1,0,1, 0, 1;
   - `txInterrupt`=1 exactly 44 cycles after the line falls.
3. Send 0x07 (parity 1):
   - parity bit = 1;
   - loopback into the receiver (same `BAUD_CNT`) → `receivedData`=0x07, `parityError`=0.
4. Pulse start with 0x3C at cycle 10 of a frame carrying 0x81 → frame carries 0x81 unchanged; no second frame.
5. Start 0x55 the cycle `txInterrupt` rises, with `clearInterrupt` held high that same cycle:
   - interrupt stays 1;
   - next start bit follows the stop bit with no gap.
6. Assert `rst` during the DATA bit 4 window → next cycle line=1, `txBusy`=0; a new start of 0xFF then sends a clean frame with parity 0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver: frame geometry,
// default baud divisor and the FSM state encoding used on both sides.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

    localparam int UART_DATA_BITS        = 8;
    localparam int UART_FRAME_BITS       = 11;   // start + 8 data + parity + stop
    localparam int UART_BAUD_CNT_DEFAULT = 5199; // bit period = BAUD_CNT + 1 clocks

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period timer. While run is high the counter steps 0..BAUD_CNT and
// bit_tick marks the last cycle of each bit period; run low holds it at 0 so
// every frame starts on a fresh, full-length bit.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   run      in   enable; counter cleared while low
//   bit_tick out  high in the final cycle of a bit period
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_CNT = UART_BAUD_CNT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_tick
);

    localparam int CW = (BAUD_CNT > 0) ? $clog2(BAUD_CNT + 1) : 1;

    logic [CW-1:0] tick_cnt;

    assign bit_tick = run && (tick_cnt == CW'(BAUD_CNT));

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            tick_cnt <= '0;
        end else if (bit_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/device_uart_tx.sv
// -----------------------------------------------------------------------------
// device_uart_tx
// UART transmitter: one byte per request, framed as start(0), 8 data bits
// LSB first, even parity, stop(1). All outputs are registered.
//
// State table:
//   state     | meaning
//   ST_IDLE   | line high, waiting for transmitStart
//   ST_START  | driving start bit (0)
//   ST_DATA   | driving shift_r[0], bit_idx counts 0..7
//   ST_PARITY | driving parity_r
//   ST_STOP   | driving stop bit (1); end raises txInterrupt
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   transmitData   in   byte to send, sampled when a start is accepted
//   transmitStart  in   one-cycle request, honoured only in ST_IDLE
//   clearInterrupt in   clears txInterrupt (a simultaneous set wins)
//   serialDataTX   out  serial line, idles high
//   txBusy         out  frame in progress
//   txInterrupt    out  sticky frame-done flag
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module device_uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_CNT = UART_BAUD_CNT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] transmitData,
    input  logic                      transmitStart,
    input  logic                      clearInterrupt,
    output logic                      serialDataTX,
    output logic                      txBusy,
    output logic                      txInterrupt
);

    uart_state_e               state;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [2:0]                bit_idx;
    logic                      parity_r;
    logic                      bit_tick;
    logic                      run;
    logic                      irq_set;

    assign run     = (state != ST_IDLE);
    assign irq_set = (state == ST_STOP) && bit_tick;

    uart_baud_tick #(
        .BAUD_CNT (BAUD_CNT)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .bit_tick (bit_tick)
    );

    // The line register is loaded with the value of the bit being entered, so
    // the output changes on the same edge as the state and stays glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            shift_r      <= '0;
            bit_idx      <= '0;
            parity_r     <= 1'b0;
            serialDataTX <= 1'b1;
            txBusy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (transmitStart) begin
                        shift_r      <= transmitData;
                        parity_r     <= even_parity(transmitData);
                        state        <= ST_START;
                        serialDataTX <= 1'b0;
                        txBusy       <= 1'b1;
                    end else begin
                        serialDataTX <= 1'b1;
                        txBusy       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        state        <= ST_DATA;
                        bit_idx      <= '0;
                        serialDataTX <= shift_r[0];
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift_r <= {1'b0, shift_r[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            state        <= ST_PARITY;
                            serialDataTX <= parity_r;
                        end else begin
                            serialDataTX <= shift_r[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        state        <= ST_STOP;
                        serialDataTX <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        state        <= ST_IDLE;
                        serialDataTX <= 1'b1;
                        txBusy       <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    serialDataTX <= 1'b1;
                    txBusy       <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txInterrupt <= 1'b0;
        end else if (irq_set) begin
            txInterrupt <= 1'b1;
        end else if (clearInterrupt) begin
            txInterrupt <= 1'b0;
        end
    end

endmodule

// File: tb/tb_device_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_device_uart_tx
// Bench for device_uart_tx with BAUD_CNT = 3 (4 clocks per bit, 44-clock
// frame). Stimulus pushes the expected byte and parity into exp_q; an
// independent line monitor decodes each frame like a receiver would and
// compares it against the head of the queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_device_uart_tx;
    import uart_pkg::*;

    localparam int BAUD      = 3;
    localparam int BIT_CYC   = BAUD + 1;
    localparam int FRAME_CYC = UART_FRAME_BITS * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] transmitData = 8'h00;
    logic       transmitStart = 1'b0;
    logic       clearInterrupt = 1'b0;
    logic       serialDataTX;
    logic       txBusy;
    logic       txInterrupt;

    typedef struct packed {
        logic [7:0] data;
        logic       parity;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_seen = 0;

    device_uart_tx #(.BAUD_CNT(BAUD)) dut (
        .clk            (clk),
        .rst            (rst),
        .transmitData   (transmitData),
        .transmitStart  (transmitStart),
        .clearInterrupt (clearInterrupt),
        .serialDataTX   (serialDataTX),
        .txBusy         (txBusy),
        .txInterrupt    (txInterrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic finish_frame(input logic [10:0] bits, input logic glitch);
        exp_t e;
        frames_seen++;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got frame data %0h expected no frame", bits[8:1]);
        end else begin
            e = exp_q.pop_front();
            check("frame_start_bit", {31'd0, bits[0]}, 32'd0);
            check("frame_data", {24'd0, bits[8:1]}, {24'd0, e.data});
            check("frame_parity_bit", {31'd0, bits[9]}, {31'd0, e.parity});
            check("frame_parity_error", {31'd0, bits[9] ^ (^bits[8:1])}, 32'd0);
            check("frame_stop_bit", {31'd0, bits[10]}, 32'd1);
            check("frame_bit_width", {31'd0, glitch}, 32'd0);
        end
    endtask

    // Line monitor: a falling edge on an idle line starts a frame; the first
    // cycle of each bit is its value and the remaining cycles must match it.
    initial begin : monitor
        logic        active;
        logic        prev;
        logic        glitch;
        logic [10:0] bits;
        int          pos;
        active = 1'b0;
        prev   = 1'b1;
        glitch = 1'b0;
        bits   = '0;
        pos    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
                prev   = 1'b1;
            end else begin
                if (!active && prev && !serialDataTX) begin
                    active = 1'b1;
                    pos    = 0;
                    glitch = 1'b0;
                    bits   = '0;
                end
                if (active) begin
                    if (pos % BIT_CYC == 0)
                        bits[pos / BIT_CYC] = serialDataTX;
                    else if (serialDataTX !== bits[pos / BIT_CYC])
                        glitch = 1'b1;
                    if (pos == FRAME_CYC - 1) begin
                        finish_frame(bits, glitch);
                        active = 1'b0;
                    end
                    pos++;
                end
                prev = serialDataTX;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the first frame cycle.
    task automatic send(input logic [7:0] d, input logic p, input bit expect_frame);
        exp_t e;
        transmitData  = d;
        transmitStart = 1'b1;
        if (expect_frame) begin
            e.data   = d;
            e.parity = p;
            exp_q.push_back(e);
        end
        @(negedge clk);
        transmitStart = 1'b0;
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (!txInterrupt && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic clear_irq();
        clearInterrupt = 1'b1;
        @(negedge clk);
        clearInterrupt = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_line", {31'd0, serialDataTX}, 32'd1);
            check("idle_busy", {31'd0, txBusy}, 32'd0);
            check("idle_irq", {31'd0, txInterrupt}, 32'd0);
        end

        // 2: 0xA5, parity 0, interrupt 44 cycles after the line falls
        send(8'hA5, 1'b0, 1'b1);
        check("a5_line_falls", {31'd0, serialDataTX}, 32'd0);
        check("a5_busy_rises", {31'd0, txBusy}, 32'd1);
        wait_irq(n);
        check("a5_irq_latency", n, 44);
        check("a5_busy_falls", {31'd0, txBusy}, 32'd0);
        check("a5_line_idle", {31'd0, serialDataTX}, 32'd1);
        clear_irq();
        check("irq_cleared", {31'd0, txInterrupt}, 32'd0);

        // 3 + 5: 0x07 (parity 1); clear during the set cycle, then 0x55
        // started in the first idle cycle.
        send(8'h07, 1'b1, 1'b1);
        tick(43);
        check("07_irq_before_end", {31'd0, txInterrupt}, 32'd0);
        check("07_busy_last_stop", {31'd0, txBusy}, 32'd1);
        clearInterrupt = 1'b1;
        @(negedge clk);
        clearInterrupt = 1'b0;
        check("set_wins_irq", {31'd0, txInterrupt}, 32'd1);
        check("07_busy_falls", {31'd0, txBusy}, 32'd0);
        send(8'h55, 1'b0, 1'b1);
        check("b2b_line_falls", {31'd0, serialDataTX}, 32'd0);
        check("b2b_busy", {31'd0, txBusy}, 32'd1);
        check("b2b_irq_kept", {31'd0, txInterrupt}, 32'd1);
        clear_irq();
        wait_irq(n);
        check("55_irq_latency", n, 43);
        clear_irq();

        // 4: start 0x3C at cycle 10 of a 0x81 frame is ignored
        send(8'h81, 1'b0, 1'b1);
        tick(9);
        transmitData  = 8'h3C;
        transmitStart = 1'b1;
        @(negedge clk);
        transmitStart = 1'b0;
        wait_irq(n);
        check("81_irq_latency", n, 34);
        tick(60);
        check("81_no_second_busy", {31'd0, txBusy}, 32'd0);
        check("81_no_second_line", {31'd0, serialDataTX}, 32'd1);

        // 6: reset in the data-bit-4 window, then a clean 0xFF frame
        send(8'h5A, 1'b0, 1'b0);
        tick(21);
        check("pre_rst_busy", {31'd0, txBusy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_line", {31'd0, serialDataTX}, 32'd1);
        check("rst_busy", {31'd0, txBusy}, 32'd0);
        check("rst_irq", {31'd0, txInterrupt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        check("post_rst_line", {31'd0, serialDataTX}, 32'd1);
        send(8'hFF, 1'b0, 1'b1);
        check("ff_line_falls", {31'd0, serialDataTX}, 32'd0);
        wait_irq(n);
        check("ff_irq_latency", n, 44);
        tick(10);

        check("pending_frames", exp_q.size(), 0);
        check("frames_seen", frames_seen, 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
